// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target responder that stands in for an
// ADT7420 temperature sensor: the protocol FSM state type, the register map
// addresses and the default 7-bit device address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_MACK,
    IGNORE
  } i2c_state_t;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_STATUS   = 8'h02;
  localparam logic [7:0] REG_CONFIG   = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h48;

endpackage

// File: rtl/i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner
// Brings the raw SCL/SDA lines into the clk domain and turns them into
// single-cycle bus events.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   scl_in, sda_in    raw bus lines
//   scl_rise/scl_fall one-cycle SCL edge pulses
//   start/stop        one-cycle START / STOP condition pulses
//   sda_s             conditioned SDA level, used for bit sampling
//
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to insert a 3-sample
// majority filter on both lines after the synchronizer.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_bus_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_f;
  logic                   sda_f;
  logic                   scl_q;
  logic                   sda_q;

  // Synchronizers reset to the idle-high bus level so that leaving reset
  // never looks like an edge or a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  // Majority of the last three samples: a single-cycle glitch can never win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
      scl_f    <= (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                  (scl_hist[1] & scl_hist[2]);
      sda_f    <= (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                  (sda_hist[1] & sda_hist[2]);
    end
  end
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP need SCL high on both samples, so an SDA change that races an
  // SCL edge is not mistaken for a bus condition.
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;
  assign sda_s    = sda_f;

endmodule

// File: rtl/i2c_target_responder.sv
// ---------------------------------------------------------------------------
// i2c_target_responder
// I2C target that answers like an ADT7420 temperature sensor, for bring-up
// of the sensor-controller path without the physical part.
//
// Ports:
//   clk, rst_n   system clock (>= 16x SCL), asynchronous active-low reset
//   scl_in       raw SCL
//   sda_in       raw SDA
//   sda_oe       1 = pull SDA low, 0 = release (open drain)
//   a_pins       A1,A0 address select, replaces ADDR_BASE[1:0]
//   temp_value   live temperature word served at 0x00/0x01
//   status_in    value served at 0x02
//   config_reg   R/W register 0x03
//   wr_strobe    one-cycle pulse when config_reg is written
//   busy         high from an addressed START until STOP
//
// Build option: I2C_TARGET_GLITCH_FILTER_EN (see i2c_bus_conditioner).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR_BASE   = DEFAULT_DEV_ADDR,
  parameter logic [7:0] DEVICE_ID   = 8'hCB,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [1:0]  a_pins,
  input  logic [15:0] temp_value,
  input  logic [7:0]  status_in,
  output logic [7:0]  config_reg,
  output logic        wr_strobe,
  output logic        busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic       sda_s;

  i2c_state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] tx;
  logic [7:0] pointer;
  logic [7:0] snap_lsb;
  logic [7:0] rd_byte;
  logic       rw;
  logic       mack;

  i2c_bus_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  // Register read mux. The MSB of the temperature comes live; the LSB comes
  // from the snapshot taken when the MSB was loaded, so a 2-byte read is
  // coherent.
  always_comb begin
    rd_byte = 8'h00;
    case (pointer)
      REG_TEMP_MSB: rd_byte = temp_value[15:8];
      REG_TEMP_LSB: rd_byte = snap_lsb;
      REG_STATUS:   rd_byte = status_in;
      REG_CONFIG:   rd_byte = config_reg;
      REG_ID:       rd_byte = DEVICE_ID;
      default:      rd_byte = 8'h00;
    endcase
  end

  // Protocol FSM. All SDA changes happen on the cycle after a detected
  // scl_fall, which gives the initiator hold time after SCL goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= '0;
      pointer    <= '0;
      snap_lsb   <= '0;
      config_reg <= '0;
      wr_strobe  <= 1'b0;
      busy       <= 1'b0;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      mack       <= 1'b1;
    end else begin
      wr_strobe <= 1'b0;

      if (stop) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        // Receive shifting is shared by every state that takes a byte in.
        if (scl_rise && bit_cnt != 4'd8 &&
            (state == ADDR || state == PTR || state == WDATA)) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end

        case (state)
          IDLE, IGNORE: begin
            sda_oe <= 1'b0;
          end

          ADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg[7:1] == {ADDR_BASE[6:2], a_pins}) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
                state  <= ADDR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!rw) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= PTR;
              end else begin
                // Releasing the ACK and driving data bit 7 share one cycle.
                tx      <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                bit_cnt <= 4'd1;
                if (pointer == REG_TEMP_MSB) snap_lsb <= temp_value[7:0];
                state   <= RDATA;
              end
            end
          end

          PTR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              pointer <= shreg;
              sda_oe  <= 1'b1;
              state   <= PTR_ACK;
            end
          end

          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end

          WDATA: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              if (pointer == REG_CONFIG) begin
                config_reg <= shreg;
                wr_strobe  <= 1'b1;
              end
              pointer <= pointer + 8'd1;
              state   <= WDATA_ACK;
            end
          end

          RDATA: begin
            // bit_cnt counts bits already placed on SDA.
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RDATA_MACK;
              end else begin
                sda_oe  <= ~tx[6];
                tx      <= {tx[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RDATA_MACK: begin
            if (scl_rise) begin
              mack    <= sda_s;
              pointer <= pointer + 8'd1;
            end else if (scl_fall) begin
              if (!mack) begin
                tx      <= rd_byte;
                sda_oe  <= ~rd_byte[7];
                bit_cnt <= 4'd1;
                if (pointer == REG_TEMP_MSB) snap_lsb <= temp_value[7:0];
                state   <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end

          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_responder
// Bit-banged I2C initiator driving the responder through directed
// transactions. Expected values are queued before each transaction and a
// separate monitor process compares them against what the initiator observes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_target_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic [1:0]  a_pins = 2'b00;
  logic [15:0] temp_value = 16'h0000;
  logic [7:0]  status_in = 8'h5C;
  logic [7:0]  config_reg;
  logic        wr_strobe;
  logic        busy;

  // Open-drain wired-AND of initiator and target.
  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (m_scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .a_pins     (a_pins),
    .temp_value (temp_value),
    .status_in  (status_in),
    .config_reg (config_reg),
    .wr_strobe  (wr_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle counters sampled away from the active edge.
  int strobe_cnt = 0;
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    if (sda_oe)    oe_cnt <= oe_cnt + 1;
  end

  // Scoreboard
  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  string       obs_name;
  logic [15:0] obs_val;
  event        obs_ev;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic expectValue(input string n, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string n, input logic [15:0] v);
    obs_name = n;
    obs_val  = v;
    ->obs_ev;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(obs_ev);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL %s: got %h, nothing expected", obs_name, obs_val);
      end else begin
        e = exp_q.pop_front();
        if (e.name != obs_name || e.val !== obs_val) begin
          tests_failed++;
          $display("[TB] FAIL %s: got %h, expected %s = %h",
                   obs_name, obs_val, e.name, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Bus primitives (SCL low on entry/exit, 400 ns per bit)
  task automatic applyStimulus(input logic b);
    #100 m_sda = b;
    #100 m_scl = 1'b1;
    #200 m_scl = 1'b0;
  endtask

  task automatic sampleBit(output logic b);
    #100 m_sda = 1'b1;
    #100 m_scl = 1'b1;
    #100 b = sda_bus;
    #100 m_scl = 1'b0;
  endtask

  task automatic i2cStart;
    if (!m_scl) begin
      #100 m_sda = 1'b1;
      #100 m_scl = 1'b1;
      #200;
    end
    m_sda = 1'b0;
    #200 m_scl = 1'b0;
  endtask

  task automatic i2cStop;
    #100 m_sda = 1'b0;
    #100 m_scl = 1'b1;
    #200 m_sda = 1'b1;
    #200;
  endtask

  task automatic sendByte(input string n, input logic [7:0] b, input logic exp_ack);
    logic ack;
    expectValue(n, {15'h0, exp_ack});
    for (int i = 7; i >= 0; i--) applyStimulus(b[i]);
    sampleBit(ack);
    checkOutput(n, {15'h0, ack});
  endtask

  task automatic recvByte(input string n, input logic [7:0] exp_b, input logic nack);
    logic [7:0] b;
    logic       bit_v;
    expectValue(n, {8'h00, exp_b});
    for (int i = 7; i >= 0; i--) begin
      sampleBit(bit_v);
      b[i] = bit_v;
    end
    applyStimulus(nack);
    checkOutput(n, {8'h00, b});
  endtask

  task automatic checkSig(input string n, input logic [15:0] actual, input logic [15:0] required);
    expectValue(n, required);
    checkOutput(n, actual);
  endtask

  int strobe_base;
  int oe_base;

  initial begin : stimulus
    // Reset state
    #23;
    checkSig("rst_sda_oe", {15'h0, sda_oe}, 16'h0000);
    checkSig("rst_config", {8'h0, config_reg}, 16'h0000);
    checkSig("rst_wr_strobe", {15'h0, wr_strobe}, 16'h0000);
    checkSig("rst_busy", {15'h0, busy}, 16'h0000);
    #50 rst_n = 1'b1;
    #200;

    // Device ID through a pointer write and repeated START
    i2cStart();
    sendByte("id_addr_w", 8'h90, 1'b0);
    checkSig("id_busy_set", {15'h0, busy}, 16'h0001);
    sendByte("id_ptr", 8'h0B, 1'b0);
    i2cStart();
    sendByte("id_addr_r", 8'h91, 1'b0);
    recvByte("id_data", 8'hCB, 1'b1);
    checkSig("id_busy_ignore", {15'h0, busy}, 16'h0001);
    i2cStop();
    checkSig("id_busy_clear", {15'h0, busy}, 16'h0000);

    // Coherent 2-byte temperature read
    temp_value = 16'h0C80;
    i2cStart();
    sendByte("tmp_addr_w", 8'h90, 1'b0);
    sendByte("tmp_ptr", 8'h00, 1'b0);
    i2cStart();
    sendByte("tmp_addr_r", 8'h91, 1'b0);
    recvByte("tmp_msb", 8'h0C, 1'b0);
    temp_value = 16'h1234;
    recvByte("tmp_lsb_snap", 8'h80, 1'b1);
    i2cStop();

    // Config write, then a discarded write to 0x04 in the same burst
    strobe_base = strobe_cnt;
    i2cStart();
    sendByte("cfg_addr_w", 8'h90, 1'b0);
    sendByte("cfg_ptr", 8'h03, 1'b0);
    sendByte("cfg_data", 8'hA5, 1'b0);
    sendByte("cfg_next_data", 8'h77, 1'b0);
    i2cStop();
    checkSig("cfg_value", {8'h0, config_reg}, 16'h00A5);
    checkSig("cfg_strobe_cycles", 16'(strobe_cnt - strobe_base), 16'h0001);
    i2cStart();
    sendByte("cfg_rb_addr_w", 8'h90, 1'b0);
    sendByte("cfg_rb_ptr", 8'h03, 1'b0);
    i2cStart();
    sendByte("cfg_rb_addr_r", 8'h91, 1'b0);
    recvByte("cfg_rb_data", 8'hA5, 1'b1);
    i2cStop();

    // Wrong address: 0x49 with a_pins=00
    oe_base = oe_cnt;
    i2cStart();
    sendByte("bad_addr_nack", 8'h92, 1'b1);
    checkSig("bad_addr_busy", {15'h0, busy}, 16'h0000);
    i2cStop();
    checkSig("bad_addr_no_oe", 16'(oe_cnt - oe_base), 16'h0000);
    checkSig("bad_addr_config", {8'h0, config_reg}, 16'h00A5);

    // Same address accepted once a_pins selects it
    a_pins = 2'b01;
    i2cStart();
    sendByte("apins_addr_ack", 8'h92, 1'b0);
    i2cStop();
    a_pins = 2'b00;

    // Status register
    i2cStart();
    sendByte("st_addr_w", 8'h90, 1'b0);
    sendByte("st_ptr", 8'h02, 1'b0);
    i2cStart();
    sendByte("st_addr_r", 8'h91, 1'b0);
    recvByte("st_data", 8'h5C, 1'b1);
    i2cStop();

    // Pointer wrap 0xFF -> 0x00 (temp_value is 16'h1234)
    i2cStart();
    sendByte("wrap_addr_w", 8'h90, 1'b0);
    sendByte("wrap_ptr", 8'hFF, 1'b0);
    i2cStart();
    sendByte("wrap_addr_r", 8'h91, 1'b0);
    recvByte("wrap_byte_ff", 8'h00, 1'b0);
    recvByte("wrap_byte_00", 8'h12, 1'b1);
    i2cStop();

    // Reset in the middle of a read while the target drives a 0
    temp_value = 16'h0C80;
    i2cStart();
    sendByte("mr_addr_w", 8'h90, 1'b0);
    sendByte("mr_ptr", 8'h00, 1'b0);
    i2cStart();
    sendByte("mr_addr_r", 8'h91, 1'b0);
    #100;
    checkSig("mr_driving_zero", {15'h0, sda_oe}, 16'h0001);
    #3 rst_n = 1'b0;
    #1;
    checkSig("mr_sda_oe", {15'h0, sda_oe}, 16'h0000);
    checkSig("mr_busy", {15'h0, busy}, 16'h0000);
    checkSig("mr_config", {8'h0, config_reg}, 16'h0000);
    checkSig("mr_wr_strobe", {15'h0, wr_strobe}, 16'h0000);
    #50 rst_n = 1'b1;
    i2cStop();

    // Normal transaction after reset
    i2cStart();
    sendByte("post_addr_w", 8'h90, 1'b0);
    sendByte("post_ptr", 8'h03, 1'b0);
    sendByte("post_data", 8'h5A, 1'b0);
    i2cStop();
    checkSig("post_config", {8'h0, config_reg}, 16'h005A);
    i2cStart();
    sendByte("post_rb_addr_w", 8'h90, 1'b0);
    sendByte("post_rb_ptr", 8'h03, 1'b0);
    i2cStart();
    sendByte("post_rb_addr_r", 8'h91, 1'b0);
    recvByte("post_rb_data", 8'h5A, 1'b1);
    i2cStop();

    #200;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
